// File: rtl/pc_fetch_ctrl_if.sv
// Fetch-stage bus bundle: PC adder loop, instruction memory handshake,
// decode-side buffer, and the redirect/stall/halt controls from later stages.
interface pc_fetch_ctrl_if;
  logic [15:0] pc;
  logic [15:0] pc_plus2;
  logic        imem_req;
  logic        imem_ready;
  logic [15:0] imem_data;
  logic        instr_valid;
  logic [15:0] instr;
  logic [15:0] instr_pc;
  logic        stall;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        halt_in;
  logic        halted;

  modport master (
    output pc,
    input  pc_plus2,
    output imem_req,
    input  imem_ready,
    input  imem_data,
    output instr_valid,
    output instr,
    output instr_pc,
    input  stall,
    input  redirect_valid,
    input  redirect_pc,
    input  halt_in,
    output halted
  );

  modport slave (
    input  pc,
    output pc_plus2,
    input  imem_req,
    output imem_ready,
    output imem_data,
    input  instr_valid,
    input  instr,
    input  instr_pc,
    output stall,
    output redirect_valid,
    output redirect_pc,
    output halt_in,
    input  halted
  );
endinterface

// File: rtl/pc_fetch_ctrl.sv
// Program counter and instruction-fetch sequencer with a one-entry decode buffer,
// stall back-pressure, redirect flush and halt.
module pc_fetch_ctrl #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input logic            clk,
  input logic            rst,
  pc_fetch_ctrl_if.master bus
);

  typedef enum logic [0:0] {StFetch, StHalted} state_e;

  state_e      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] instr_q, instr_d;
  logic [15:0] instr_pc_q, instr_pc_d;
  logic        instr_valid_q, instr_valid_d;

  logic full;
  logic req;
  logic accept;
  logic consume;

  // Buffer is occupied and decode is not taking it this cycle.
  assign full    = instr_valid_q & bus.stall;
  assign req     = (state_q == StFetch) & ~full & ~bus.redirect_valid & ~rst;
  assign accept  = req & bus.imem_ready;
  assign consume = instr_valid_q & ~bus.stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StFetch;
      pc_q          <= RESET_PC;
      instr_q       <= 16'h0000;
      instr_pc_q    <= 16'h0000;
      instr_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      instr_valid_q <= instr_valid_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    instr_valid_d = instr_valid_q;

    unique case (state_q)
      StFetch: begin
        if (bus.redirect_valid) begin
          // The redirecting instruction is older than anything buffered here.
          pc_d          = bus.redirect_pc & 16'hFFFE;
          instr_valid_d = 1'b0;
        end else if (consume && bus.halt_in) begin
          state_d       = StHalted;
          instr_valid_d = 1'b0;
        end else if (accept) begin
          instr_d       = bus.imem_data;
          instr_pc_d    = pc_q;
          instr_valid_d = 1'b1;
          pc_d          = bus.pc_plus2;
        end else if (consume) begin
          instr_valid_d = 1'b0;
        end
      end
      StHalted: begin
        instr_valid_d = 1'b0;
      end
      default: begin
        state_d = StFetch;
      end
    endcase
  end

  assign bus.pc          = pc_q;
  assign bus.imem_req    = req;
  assign bus.instr_valid = instr_valid_q;
  assign bus.instr       = instr_q;
  assign bus.instr_pc    = instr_pc_q;
  assign bus.halted      = (state_q == StHalted);

endmodule
